// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Talks to a variable-latency
// instruction memory and absorbs stalls (HOLD) and redirects behind an in-flight fetch (DRAIN).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  state_t      state, state_nx;
  ifid_t       ifid_q, ifid_nx;
  logic [31:0] pc, pc_nx, pending_target, pending_nx, hold_buf, hold_nx;
  logic [31:0] pc_plus4, target;
  logic        redirect;

  assign pc_plus4       = pc + 32'd4;
  assign redirect       = (jump | branch_taken) & ~stall;
  assign target         = jump ? {ifid_q.pc_plus4[31:28], jump_index, 2'b00} : branch_target;
  assign imem_req       = ~reset & ((state == FETCH) | (state == DRAIN));
  assign imem_addr      = pc;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
  assign if_id_valid    = ifid_q.valid;
  assign opcode         = ifid_q.instr[31:26];

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pending_nx = pending_target;
    hold_nx    = hold_buf;
    ifid_nx    = ifid_q;
    case (state)
      FETCH: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_nx         = target;
            ifid_nx.instr = '0;
            ifid_nx.valid = 1'b0;
          end else if (stall) begin
            hold_nx  = imem_rdata;
            state_nx = HOLD;
          end else begin
            ifid_nx  = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
            pc_nx    = pc_plus4;
          end
        end else if (redirect) begin
          // the request at the old pc is still owed a response; wait it out
          pending_nx    = target;
          ifid_nx.instr = '0;
          ifid_nx.valid = 1'b0;
          state_nx      = DRAIN;
        end else if (!stall) begin
          ifid_nx.instr = '0;
          ifid_nx.valid = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx         = target;
          hold_nx       = '0;
          ifid_nx.instr = '0;
          ifid_nx.valid = 1'b0;
          state_nx      = FETCH;
        end else if (!stall) begin
          ifid_nx  = '{instr: hold_buf, pc_plus4: pc_plus4, valid: 1'b1};
          pc_nx    = pc_plus4;
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        if (!stall) begin
          ifid_nx.instr = '0;
          ifid_nx.valid = 1'b0;
        end
        if (redirect) pending_nx = target;
        // a redirect landing with the stale response is the newest target
        if (imem_valid) begin
          pc_nx    = redirect ? target : pending_target;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pending_target <= '0;
      hold_buf       <= '0;
      ifid_q         <= '0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      pending_target <= pending_nx;
      hold_buf       <= hold_nx;
      ifid_q         <= ifid_nx;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: program-flow reference model plus
// a directed wrap/reset run on a second instance with RESET_PC at the top of memory.
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, deliveries = 0, idle = 0;

  // instance 0: randomized
  logic        rst0, stall0, bt0, j0, req0, v0, val0;
  logic [31:0] btgt0, addr0, rd0, instr0, pcp40;
  logic [25:0] ji0;
  logic [5:0]  op0;
  // instance 1: directed, reset pc at the wrap point
  logic        rst1, stall1, bt1, j1, req1, v1, val1;
  logic [31:0] btgt1, addr1, rd1, instr1, pcp41;
  logic [25:0] ji1;
  logic [5:0]  op1;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .reset(rst0), .stall(stall0), .branch_taken(bt0), .branch_target(btgt0),
    .jump(j0), .jump_index(ji0), .imem_req(req0), .imem_addr(addr0), .imem_valid(v0),
    .imem_rdata(rd0), .if_id_instr(instr0), .if_id_pc_plus4(pcp40), .if_id_valid(val0),
    .opcode(op0));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .reset(rst1), .stall(stall1), .branch_taken(bt1), .branch_target(btgt1),
    .jump(j1), .jump_index(ji1), .imem_req(req1), .imem_addr(addr1), .imem_valid(v1),
    .imem_rdata(rd1), .if_id_instr(instr1), .if_id_pc_plus4(pcp41), .if_id_valid(val1),
    .opcode(op1));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  exp_t        exp_q[$];
  logic        mon_en = 1'b0;
  logic        redir_edge = 1'b0;
  // reference view of the IF/ID register as decode should see it
  logic [31:0] m_instr = '0, m_pcp4 = '0;
  logic        m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'h0000_0000: r = 32'h2008_0005;
      32'h0000_0004: r = 32'h8D09_0004;
      default:       r = (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endcase
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.instr = mem_word(pc);
    e.pcp4  = pc + 32'd4;
    return e;
  endfunction

  // monitor: IF/ID is rewritten on every unstalled edge (instruction or bubble) and frozen otherwise
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        idle++;
        if (redir_edge) chk("redirect_bubble", {31'd0, val0}, 32'd0);
        if (stall0) begin
          chk("stall_instr", instr0, m_instr);
          chk("stall_pcp4", pcp40, m_pcp4);
          chk("stall_valid", {31'd0, val0}, {31'd0, m_valid});
        end else if (val0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc_plus4 %h expected none", pcp40);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_instr", instr0, e.instr);
            chk("deliver_pcp4", pcp40, e.pcp4);
            chk("deliver_opcode", {26'd0, op0}, {26'd0, e.instr[31:26]});
            m_instr = e.instr;
            m_pcp4  = e.pcp4;
            m_valid = 1'b1;
            exp_q.push_back(mk(e.pcp4));
            deliveries++;
            idle = 0;
          end
        end else begin
          chk("bubble_instr", instr0, 32'd0);
          chk("bubble_opcode", {26'd0, op0}, 32'd0);
          chk("bubble_pcp4", pcp40, m_pcp4);
          m_instr = '0;
          m_valid = 1'b0;
        end
        if (idle > 300) begin
          checks++;
          errors++;
          $display("FAIL watchdog: got %0d idle cycles required at most 300", idle);
          idle = 0;
        end
      end
    end
  end

  initial begin
    logic        outstanding;
    logic [31:0] oaddr, tgt;
    int          cnt;
    outstanding = 1'b0;
    oaddr = '0;
    cnt = 0;
    {rst0, stall0, bt0, j0, v0} = 5'b10000;
    btgt0 = '0; ji0 = '0; rd0 = '0;
    {rst1, stall1, bt1, j1, v1} = 5'b10000;
    btgt1 = '0; ji1 = '0; rd1 = '0;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'd0, req0}, 32'd0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_instr", instr0, 32'd0);
    chk("rst_pcp4", pcp40, 32'd0);
    chk("rst_valid", {31'd0, val0}, 32'd0);

    // directed: wrap of pc+4 and reset in the middle of DRAIN
    chk("u1_rst_req", {31'd0, req1}, 32'd0);
    rst1 = 1'b0;
    #1;
    chk("u1_first_req", {31'd0, req1}, 32'd1);
    chk("u1_first_addr", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    v1 = 1'b1;
    rd1 = 32'h2008_0005;
    @(negedge clk);
    v1 = 1'b0;
    chk("u1_valid", {31'd0, val1}, 32'd1);
    chk("u1_instr", instr1, 32'h2008_0005);
    chk("u1_pcp4_wrap", pcp41, 32'h0);
    chk("u1_opcode", {26'd0, op1}, 32'd8);
    chk("u1_next_addr", addr1, 32'h0);
    bt1 = 1'b1;
    btgt1 = 32'h40;
    @(negedge clk);
    bt1 = 1'b0;
    chk("u1_drain_bubble", {31'd0, val1}, 32'd0);
    chk("u1_drain_req", {31'd0, req1}, 32'd1);
    chk("u1_drain_addr", addr1, 32'h0);
    rst1 = 1'b1;
    #1;
    chk("u1_midrain_rst_req", {31'd0, req1}, 32'd0);
    chk("u1_midrain_rst_instr", instr1, 32'd0);

    // randomized run on u0 against the program-flow model
    rst0 = 1'b0;
    exp_q.push_back(mk(32'h0));
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      v0 = 1'b0;
      rd0 = $urandom;
      if (outstanding) begin
        chk("req_held", {31'd0, req0}, 32'd1);
        chk("addr_held", addr0, oaddr);
        cnt--;
        if (cnt == 0) begin
          v0 = 1'b1;
          rd0 = mem_word(oaddr);
          outstanding = 1'b0;
        end
      end else if (req0) begin
        outstanding = 1'b1;
        oaddr = addr0;
        cnt = int'($urandom_range(1, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        v0 = 1'b1;
        rd0 = 32'hDEAD_BEEF;
      end
      stall0 = ($urandom_range(0, 3) == 0);
      j0     = ($urandom_range(0, 29) == 0);
      bt0    = ($urandom_range(0, 19) == 0);
      ji0    = 26'($urandom);
      btgt0  = $urandom & 32'hFFFF_FFFC;
      redir_edge = (j0 || bt0) && !stall0;
      if (redir_edge) begin
        tgt = j0 ? {m_pcp4[31:28], ji0, 2'b00} : btgt0;
        exp_q.delete();
        exp_q.push_back(mk(tgt));
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("delivery_count_ok", {31'd0, deliveries >= 200}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
